// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-input result mux with a valid/ready consumer.
// Optional build macro MUX8_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       out_valid,
  output logic       busy
);

`ifdef MUX8_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic       accept_c;
  logic       more_c;
  logic [2:0] start_c;
  logic       hit_c;
  logic [2:0] win_c;

  // Search origin: stored pointer while idle, one past the current winner on release.
  always_comb begin
    start_c = 3'd0;
    if (!FIXED_PRIO) begin
      if (state == IDLE) start_c = ptr;
      else               start_c = 3'(sel + 3'd1);
    end
  end

  // First requester at or after start_c, wrapping 7 -> 0.
  always_comb begin
    logic [2:0] idx;
    hit_c = 1'b0;
    win_c = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(start_c + 3'(i));
      if (!hit_c && req[idx]) begin
        hit_c = 1'b1;
        win_c = idx;
      end
    end
  end

  assign accept_c = out_valid & out_ready;
  assign more_c   = (32'(cnt) + 32'd1) < 32'(MAX_BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      sel       <= 3'd0;
      grant     <= 8'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit_c) begin
            state     <= GRANT;
            sel       <= win_c;
            grant     <= 8'd1 << win_c;
            cnt       <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          if (accept_c && req[sel] && more_c) begin
            cnt <= CNT_W'(cnt + 1'b1);
          end else if (accept_c || !req[sel]) begin
            // Release: burst done, requester gone, or abandoned while stalled.
            if (!FIXED_PRIO) ptr <= 3'(sel + 3'd1);
            cnt <= '0;
            if (hit_c) begin
              sel   <= win_c;
              grant <= 8'd1 << win_c;
            end else begin
              state     <= IDLE;
              grant     <= 8'd0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter (MAX_BURST = 4).
module tb_mux8_rr_arbiter;

`ifdef MUX8_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .sel(sel), .grant(grant), .out_valid(out_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'h00; out_ready = 1'b0;
    #12;
    checks++;
    if ({sel, grant, out_valid, busy} !== {3'd0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: sel=%0d grant=%h ov=%b busy=%b, want 0/00/0/0", sel, grant, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if ({sel, grant, out_valid, busy} !== {3'd0, 8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_no_req[%0d]: sel=%0d grant=%h ov=%b busy=%b, want 0/00/0/0", i, sel, grant, out_valid, busy);
      end
    end
  endtask

  task automatic test_burst();
    logic [2:0] exp_rr [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
    logic [2:0] es;
    do_reset();
    req = 8'h81; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      es = FIXED ? 3'd0 : exp_rr[i];
      checks++;
      if (sel !== es || grant !== (8'd1 << es) || out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL burst_81[%0d]: sel=%0d grant=%h ov=%b busy=%b, want sel=%0d grant=%h ov=1 busy=1",
                 i, sel, grant, out_valid, busy, es, 8'd1 << es);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    req = 8'h04; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (sel !== 3'd2 || grant !== 8'h04 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: sel=%0d grant=%h ov=%b, want 2/04/1", i, sel, grant, out_valid);
      end
    end
    out_ready = 1'b1;
    cyc();
    checks++;
    if (sel !== 3'd2 || grant !== 8'h04 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_first_accept: sel=%0d grant=%h ov=%b, want 2/04/1", sel, grant, out_valid);
    end
    req = 8'h00; out_ready = 1'b0;
    cyc();
    checks++;
    if (sel !== 3'd2 || grant !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_sel_hold: sel=%0d grant=%h ov=%b busy=%b, want 2/00/0/0", sel, grant, out_valid, busy);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    req = 8'h28; out_ready = 1'b0;
    cyc();
    checks++;
    if (sel !== 3'd3 || grant !== 8'h08) begin
      errors++;
      $display("FAIL abandon_pre: sel=%0d grant=%h, want 3/08", sel, grant);
    end
    req = 8'h20;
    cyc();
    checks++;
    if (sel !== 3'd5 || grant !== 8'h20 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL abandon_switch: sel=%0d grant=%h ov=%b, want 5/20/1", sel, grant, out_valid);
    end
    // Fresh grant to 5 must allow a full burst of four before handing to 3.
    req = 8'h28; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (sel !== ((i < 3) ? 3'd5 : 3'd3) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL abandon_burst[%0d]: sel=%0d ov=%b, want sel=%0d ov=1",
                 i, sel, out_valid, (i < 3) ? 5 : 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'h04; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (sel !== 3'd2 || grant !== 8'h04 || out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL lone_regain[%0d]: sel=%0d grant=%h ov=%b busy=%b, want 2/04/1/1", i, sel, grant, out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h40; out_ready = 1'b1;
    cyc();
    cyc();
    checks++;
    if (sel !== 3'd6 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: sel=%0d ov=%b, want 6/1", sel, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, grant, out_valid, busy} !== {3'd0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_async_reset: sel=%0d grant=%h ov=%b busy=%b, want 0/00/0/0", sel, grant, out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'hFF;
    cyc();
    checks++;
    if (sel !== 3'd0 || grant !== 8'h01 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ff: sel=%0d grant=%h ov=%b, want 0/01/1", sel, grant, out_valid);
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp_rr [9] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd1};
    logic [2:0] es;
    do_reset();
    req = 8'h0A; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      es = FIXED ? 3'd1 : exp_rr[i];
      checks++;
      if (sel !== es || grant !== (8'd1 << es) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL prio_0a[%0d]: sel=%0d grant=%h ov=%b, want sel=%0d ov=1", i, sel, grant, out_valid, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_stall();
    test_abandon();
    test_back_to_back();
    test_reset_mid();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer that shares one 8-input, N-bit result multiplexer among eight requesters. It registers the 3-bit select and a one-hot grant, and presents the muxed word to a single consumer through a valid/ready handshake. Each winner may keep the mux for a bounded burst. The block sits beside the result mux in the CPU datapath: `sel` drives the mux select directly, and the consumer observes the mux output qualified by `out_valid`.

## Interface
- `MAX_BURST`, default 4: maximum accepted transfers per grant; legal range 1..16.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  8  request per mux input; bit i requests mux input i.
- `out_ready`  input  1  consumer accepts the current word this cycle.
- `sel`  output  3  registered mux select, equal to the index of the current winner.
- `grant`  output  8  registered one-hot grant; all zeros when idle.
- `out_valid`  output  1  mux output is valid for the consumer.
- `busy`  output  1  high in the GRANT state.

## Operation
- States:
  - IDLE: `grant`=0, `out_valid`=0.
  - GRANT: `grant`=onehot(`sel`), `out_valid`=1.
- Internal state:
  - `ptr` (3 bits): search start index.
  - `cnt`: accepted transfers in the current grant; width $clog2(MAX_BURST)+1.
- Winner search: the first index i with `req[i]`=1, scanning from `ptr` upward and wrapping 7→0.
- IDLE:
  - If any `req` is set: pick the winner, load `sel` and `grant`, clear `cnt`, set `out_valid`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, accept (`out_valid` && `out_ready`):
  - `cnt` increments.
  - If `req[sel]` is still 1 and `cnt`+1 < MAX_BURST: stay, with `sel` unchanged.
  - Otherwise release.
- GRANT, no accept:
  - If `req[sel]` is 1: hold all outputs.
  - If `req[sel]` is 0: abandon. Release with no transfer counted.
- Release:
  - `ptr` ← `sel`+1 (mod 8).
  - Re-search over the current `req` from the new `ptr`, excluding none. A lone requester therefore regains the mux.
  - If a winner exists: load it in the same edge. There is no idle bubble and `out_valid` stays 1.
  - Otherwise go to IDLE.
- Simultaneous accept and `req[sel]` deassertion: the transfer counts, then release.
- `sel` holds its last value in IDLE, so the mux output stays stable.

## Timing
- Reset values: `sel`=0, `grant`=0, `out_valid`=0, `busy`=0, `ptr`=0, `cnt`=0, state IDLE.
- Reset takes effect immediately on the falling edge of `rst_n`, including mid-burst.
- Arbitration latency: `req` sampled high at edge k gives `grant`/`sel`/`out_valid` valid after edge k, i.e. one cycle.
- Throughput: one word per cycle while `out_ready`=1, including across grant handovers.
- Burst with MAX_BURST=M and continuous `req` and `out_ready`: exactly M consecutive accepted cycles, then handover.
- `req` is sampled every cycle. `out_valid` and `grant` never change in a cycle where `out_valid`=1, `out_ready`=0 and `req[sel]`=1.
- `busy` equals `out_valid` at all times.

## Configuration
- `MUX8_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. The search always starts at index 0, so the lowest set index wins, and `ptr` is not updated. Burst limit and abandon rules are unchanged.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles → `grant`=0, `out_valid`=0, `sel`=0 throughout.
- MAX_BURST=4, `req`=8'h81 held, `out_ready`=1 → `sel` sequence 0,0,0,0,7,7,7,7,0…; `out_valid` continuously 1.
- `req`=8'h04, `out_ready`=0 for 3 cycles, then 1 → `sel`=2 and `grant`=8'h04 stable while stalled; first accept on cycle 4.
- Abandon:
  - Stimulus: `sel`=3 granted, `out_ready`=0, `req[3]` drops while `req[5]`=1.
  - Response: next edge `sel`=5, `grant`=8'h20, `cnt`=0, no transfer counted for 3.
- Assert `rst_n`=0 mid-burst on requester 6 → outputs immediately go to `grant`=0, `out_valid`=0, `sel`=0; after release, `req`=8'hFF → first grant `sel`=0.
- With `MUX8_ARB_FIXED_PRIO_EN` and MAX_BURST=2, `req`=8'h0A held, `out_ready`=1 → `sel` 1,1,1,1… (index 1 always rewins; requester 3 starves).
